// File: rtl/gpio_input_ctrl.sv
// Switch/button input peripheral: two-flop sync, per-button debounce, sticky press flags, registered
// read port. Define GPIO_INPUT_IRQ_EN to get a registered press-pending interrupt on irq.
module gpio_input_ctrl #(
  parameter int unsigned NUM_SW          = 16,
  parameter int unsigned NUM_BTN         = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SW-1:0]  SW,
  input  logic [NUM_BTN-1:0] BTN,
  input  logic               rd_en,
  input  logic [1:0]         rd_addr,
  output logic [31:0]        rd_data,
  output logic               rd_valid,
  output logic               irq
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [31:0] IdWord = {8'hA5, 8'(NUM_BTN), 8'(NUM_SW), 8'h01};

  logic [NUM_SW-1:0]  sw_meta_q, sw_sync_q;
  logic [NUM_BTN-1:0] btn_meta_q, btn_sync_q;
  logic [NUM_BTN-1:0] stable_q, stable_d;
  logic [CntW-1:0]    cnt_q [NUM_BTN];
  logic [CntW-1:0]    cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic [NUM_BTN-1:0] rise, clr;
  logic [31:0]        rd_data_q, rd_data_d;
  logic               rd_valid_q;

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      cnt_d[i] = '0;
      // Accept once the synced level has disagreed with stable for DEBOUNCE_CYCLES edges.
      if (btn_sync_q[i] != stable_q[i]) begin
        if (cnt_q[i] + CntOne == CntMax) begin
          stable_d[i] = btn_sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntOne;
        end
      end
    end
  end

  always_comb begin
    rise      = stable_d & ~stable_q;
    clr       = (rd_en && rd_addr == 2'd2) ? pending_q : '0;
    // Set wins over a same-edge clear; the returned value is the pre-edge pending.
    pending_d = (pending_q & ~clr) | rise;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      case (rd_addr)
        2'd0:    rd_data_d = 32'(sw_sync_q);
        2'd1:    rd_data_d = 32'(stable_q);
        2'd2:    rd_data_d = 32'(pending_q);
        default: rd_data_d = IdWord;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      stable_q   <= '0;
      pending_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sw_meta_q  <= SW;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= BTN;
      btn_sync_q <= btn_meta_q;
      stable_q   <= stable_d;
      pending_q  <= pending_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

`ifdef GPIO_INPUT_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |pending_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_input_ctrl.sv
// Bench for gpio_input_ctrl: directed scenarios with literal expectations, then random stimulus
// checked every cycle against a history-based model of sync, debounce, press flags and reads.
module tb_gpio_input_ctrl;

  localparam int unsigned Deb = 4;
`ifdef GPIO_INPUT_IRQ_EN
  localparam logic IrqEn = 1'b1;
`else
  localparam logic IrqEn = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] sw;
  logic [4:0]  btn;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        irq;

  int tests = 0;
  int fails = 0;

  gpio_input_ctrl #(
    .NUM_SW         (16),
    .NUM_BTN        (5),
    .DEBOUNCE_CYCLES(Deb)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .SW      (sw),
    .BTN     (btn),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .irq     (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: synced value is the input seen two edges earlier; a button's level flips once
  // the last Deb synced samples all disagree with it.
  logic [15:0] sw_r1, sw_r2;
  logic [4:0]  btn_r1, btn_r2;
  logic [4:0]  hist[$];
  logic [4:0]  m_stable, m_pend;
  logic [31:0] m_data;
  logic        m_valid, m_irq;
  bit          armed = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        sw_r1 = '0; sw_r2 = '0; btn_r1 = '0; btn_r2 = '0;
        hist.delete();
        m_stable = '0; m_pend = '0; m_data = '0; m_valid = 1'b0; m_irq = 1'b0;
        armed = 1;
      end else if (armed) begin
        logic [4:0] nstable, rise, ret;
        hist.push_back(btn_r2);
        if (hist.size() > Deb) void'(hist.pop_front());
        nstable = m_stable;
        for (int i = 0; i < 5; i++) begin
          bit all_diff;
          all_diff = (hist.size() == Deb);
          foreach (hist[k]) if (hist[k][i] == m_stable[i]) all_diff = 0;
          if (all_diff) nstable[i] = ~m_stable[i];
        end
        rise    = nstable & ~m_stable;
        ret     = '0;
        m_valid = rd_en;
        if (rd_en) begin
          case (rd_addr)
            2'd0: m_data = {16'h0, sw_r2};
            2'd1: m_data = {27'h0, m_stable};
            2'd2: begin m_data = {27'h0, m_pend}; ret = m_pend; end
            default: m_data = 32'hA505_1001;
          endcase
        end
        m_pend   = (m_pend & ~ret) | rise;
        m_stable = nstable;
        m_irq    = IrqEn & (|m_pend);
        sw_r2 = sw_r1; sw_r1 = sw; btn_r2 = btn_r1; btn_r1 = btn;
      end
      #1;
      if (armed) begin
        chk("model rd_valid", {31'h0, rd_valid}, {31'h0, m_valid});
        chk("model rd_data", rd_data, m_data);
        chk("model irq", {31'h0, irq}, {31'h0, m_irq});
      end
    end
  end

  // Called at a negedge; issues one read and checks the result at the following negedge.
  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    rd_en = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    chk({nm, " valid"}, {31'h0, rd_valid}, 32'h1);
    chk(nm, rd_data, exp);
  endtask

  initial begin
    int hold;
    int idx;
    rst = 1'b1; sw = 16'hBEEF; btn = '0; rd_en = 1'b0; rd_addr = '0;

    // 1: reset and switch read
    @(negedge clk);
    chk("rst rd_valid", {31'h0, rd_valid}, 32'h0);
    chk("rst irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rd(2'd0, 32'h0000_BEEF, "sw read");
    @(negedge clk);
    chk("rd_valid single pulse", {31'h0, rd_valid}, 32'h0);

    // 2: 3-cycle glitch rejected
    btn[2] = 1'b1;
    repeat (3) @(negedge clk);
    btn[2] = 1'b0;
    repeat (8) @(negedge clk);
    rd(2'd1, 32'h0, "glitch stable");
    rd(2'd2, 32'h0, "glitch pending");
    chk("glitch irq", {31'h0, irq}, 32'h0);

    // 3: held press accepted, read-to-clear
    btn[2] = 1'b1;
    repeat (8) @(negedge clk);
    chk("press irq", {31'h0, irq}, {31'h0, IrqEn});
    rd(2'd1, 32'h4, "press stable");
    rd(2'd2, 32'h4, "press pending");
    chk("irq after clear", {31'h0, irq}, 32'h0);
    rd(2'd2, 32'h0, "pending cleared");
    btn[2] = 1'b0;
    repeat (10) @(negedge clk);

    // 4: set wins over a same-edge clear
    btn[1] = 1'b1;
    repeat (8) @(negedge clk);
    btn[1] = 1'b0;
    repeat (10) @(negedge clk);
    btn[0] = 1'b1;
    repeat (5) @(negedge clk);
    rd(2'd2, 32'h2, "set-wins returned");
    chk("set-wins irq", {31'h0, irq}, {31'h0, IrqEn});
    rd(2'd2, 32'h1, "set-wins kept");

    // 5: ID word and back-to-back reads
    rd(2'd3, 32'hA505_1001, "id word");
    rd_en = 1'b1; rd_addr = 2'd0;
    @(negedge clk);
    chk("b2b0 valid", {31'h0, rd_valid}, 32'h1);
    chk("b2b0 data", rd_data, 32'h0000_BEEF);
    rd_addr = 2'd1;
    @(negedge clk);
    chk("b2b1 valid", {31'h0, rd_valid}, 32'h1);
    chk("b2b1 data", rd_data, 32'h1);
    rd_addr = 2'd2;
    @(negedge clk);
    chk("b2b2 valid", {31'h0, rd_valid}, 32'h1);
    chk("b2b2 data", rd_data, 32'h0);
    rd_addr = 2'd3;
    @(negedge clk);
    rd_en = 1'b0;
    chk("b2b3 valid", {31'h0, rd_valid}, 32'h1);
    chk("b2b3 data", rd_data, 32'hA505_1001);
    @(negedge clk);
    chk("b2b end valid", {31'h0, rd_valid}, 32'h0);

    // 6: reset mid-debounce with a read in flight
    btn[0] = 1'b0;
    repeat (10) @(negedge clk);
    btn[1] = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1; rd_en = 1'b1; rd_addr = 2'd3;
    @(negedge clk);
    rst = 1'b0; rd_en = 1'b0;
    chk("rst drops read", {31'h0, rd_valid}, 32'h0);
    chk("rst clears rd_data", rd_data, 32'h0);
    chk("rst clears irq", {31'h0, irq}, 32'h0);
    repeat (5) @(negedge clk);
    chk("held press not yet", {31'h0, irq}, 32'h0);
    @(negedge clk);
    chk("held press irq", {31'h0, irq}, {31'h0, IrqEn});
    rd(2'd2, 32'h2, "held press pending");
    btn[1] = 1'b0;

    // Random phase
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      rst     = ($urandom_range(0, 299) == 0);
      rd_en   = ($urandom_range(0, 2) == 0);
      rd_addr = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) sw = 16'($urandom);
      if (hold == 0) begin
        idx = int'($urandom_range(0, 4));
        btn[idx] = ~btn[idx];
        hold = int'($urandom_range(1, 10));
      end else begin
        hold--;
      end
      @(negedge clk);
    end
    rst = 1'b0; rd_en = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
